// File: rtl/pll_i2c_sequencer.sv
// Walks a {reg,value} config ROM range and writes each entry to the PLL over the shared I2C master.
// Boot range runs automatically after reset; failed entries are retried after a backoff.
module pll_i2c_sequencer #(
  parameter logic [6:0]  I2C_ADDR    = 7'h60,
  parameter int unsigned ROM_AW      = 8,
  parameter int unsigned BOOT_FROM   = 63,
  parameter int unsigned BOOT_TO     = 126,
  parameter int unsigned MAX_RETRIES = 3,
  parameter int unsigned RETRY_DELAY = 4800
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ROM_AW-1:0] start_from,
  input  logic [ROM_AW-1:0] start_to,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              pll_initialized,
  output logic [7:0]        err_count,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              i2c_cmd_active,
  output logic [6:0]        i2c_cmd_addr,
  output logic              i2c_cmd_read,
  output logic              i2c_cmd_high_speed,
  output logic              i2c_data_valid,
  input  logic              i2c_data_ready,
  output logic [7:0]        i2c_data_in,
  input  logic              i2c_addr_err,
  input  logic              i2c_data_err
);

  localparam int unsigned RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam int unsigned DW = (RETRY_DELAY < 2) ? 1 : $clog2(RETRY_DELAY);
  localparam logic [ROM_AW-1:0] BOOT_FROM_A = ROM_AW'(BOOT_FROM);
  localparam logic [ROM_AW-1:0] BOOT_TO_A   = ROM_AW'(BOOT_TO);
  localparam logic [RW-1:0]     RETRY_LAST  = RW'(MAX_RETRIES);
  localparam logic [DW-1:0]     DELAY_LAST  = DW'(RETRY_DELAY - 1);

  typedef enum logic [3:0] {
    S_BOOT, S_IDLE, S_FETCH, S_LATCH, S_SEND_REG, S_SEND_VAL, S_BACKOFF, S_ABORT, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ROM_AW-1:0] cid, end_q, cid_inc, launch_from, launch_to;
  logic [7:0]        reg_q, val_q;
  logic [RW-1:0]     retry_q;
  logic [DW-1:0]     delay_q;
  logic              launch, nack;

  // BOOT behaves as an unconditional start over the boot range
  assign launch      = (state == S_BOOT) || ((state == S_IDLE) && start);
  assign launch_from = (state == S_BOOT) ? BOOT_FROM_A : start_from;
  assign launch_to   = (state == S_BOOT) ? BOOT_TO_A : start_to;
  assign nack        = i2c_data_ready && (i2c_addr_err || i2c_data_err);
  assign cid_inc     = cid + ROM_AW'(1);

  assign rom_addr           = cid;
  assign i2c_cmd_addr       = I2C_ADDR;
  assign i2c_cmd_read       = 1'b0;
  assign i2c_cmd_high_speed = 1'b0;

  always_comb begin
    state_nxt      = state;
    i2c_cmd_active = 1'b0;
    i2c_data_valid = 1'b0;
    i2c_data_in    = '0;
    unique case (state)
      S_BOOT, S_IDLE: begin
        if (launch) state_nxt = (launch_from == launch_to) ? S_DONE : S_FETCH;
      end
      S_FETCH: state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_SEND_REG;
      S_SEND_REG, S_SEND_VAL: begin
        i2c_cmd_active = 1'b1;
        i2c_data_valid = 1'b1;
        i2c_data_in    = (state == S_SEND_REG) ? reg_q : val_q;
        if (nack)                    state_nxt = (retry_q == RETRY_LAST) ? S_ABORT : S_BACKOFF;
        else if (i2c_data_ready) begin
          if (state == S_SEND_REG)   state_nxt = S_SEND_VAL;
          else                       state_nxt = (cid_inc == end_q) ? S_DONE : S_FETCH;
        end
      end
      S_BACKOFF: if (delay_q == DELAY_LAST) state_nxt = S_SEND_REG;
      S_ABORT, S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_BOOT;
      cid             <= BOOT_FROM_A;
      end_q           <= BOOT_TO_A;
      reg_q           <= '0;
      val_q           <= '0;
      retry_q         <= '0;
      delay_q         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      pll_initialized <= 1'b0;
      err_count       <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (launch) begin
        cid   <= launch_from;
        end_q <= launch_to;
        error <= 1'b0;
        busy  <= 1'b1;
      end
      unique case (state)
        S_LATCH: begin
          {reg_q, val_q} <= rom_data;
          retry_q        <= '0;
        end
        S_SEND_REG, S_SEND_VAL: begin
          if (nack) begin
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            delay_q <= '0;
          end else if (i2c_data_ready && state == S_SEND_VAL) begin
            cid <= cid_inc;
          end
        end
        S_BACKOFF: begin
          if (delay_q == DELAY_LAST) retry_q <= retry_q + RW'(1);
          else                       delay_q <= delay_q + DW'(1);
        end
        S_ABORT: begin
          error <= 1'b1;
          busy  <= 1'b0;
        end
        S_DONE: begin
          done            <= 1'b1;
          busy            <= 1'b0;
          pll_initialized <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_i2c_sequencer.sv
// Directed bench: ROM and I2C target models, boot/retry/abort runs, table of later start ranges.
`timescale 1ns/1ps
module tb_pll_i2c_sequencer;

  localparam int unsigned DLY     = 50;
  localparam int unsigned ACK_DLY = 10;
  localparam int          BUDGET  = 2000;

  logic        clk, reset, start;
  logic [7:0]  start_from, start_to;
  logic        busy, done, error, pll_initialized;
  logic [7:0]  err_count;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        i2c_cmd_active, i2c_cmd_read, i2c_cmd_high_speed;
  logic [6:0]  i2c_cmd_addr;
  logic        i2c_data_valid, i2c_data_ready, i2c_addr_err, i2c_data_err;
  logic [7:0]  i2c_data_in;

  pll_i2c_sequencer #(
    .I2C_ADDR(7'h60), .ROM_AW(8), .BOOT_FROM(0), .BOOT_TO(3),
    .MAX_RETRIES(3), .RETRY_DELAY(DLY)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .start_from(start_from), .start_to(start_to),
    .busy(busy), .done(done), .error(error), .pll_initialized(pll_initialized),
    .err_count(err_count), .rom_addr(rom_addr), .rom_data(rom_data),
    .i2c_cmd_active(i2c_cmd_active), .i2c_cmd_addr(i2c_cmd_addr), .i2c_cmd_read(i2c_cmd_read),
    .i2c_cmd_high_speed(i2c_cmd_high_speed), .i2c_data_valid(i2c_data_valid),
    .i2c_data_ready(i2c_data_ready), .i2c_data_in(i2c_data_in),
    .i2c_addr_err(i2c_addr_err), .i2c_data_err(i2c_data_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: registered, one cycle latency
  logic [15:0] rom [256];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // I2C target model: acks each byte ACK_DLY cycles after valid; optional NACK injection
  logic [1:0]  inj_mode;  // 0 none, 1 data NACK once on byte 0x80, 2 addr NACK always
  logic        derr_used;
  int unsigned wcnt;
  assign i2c_data_err = i2c_data_ready && (inj_mode == 2'd1) && !derr_used && (i2c_data_in == 8'h80);
  assign i2c_addr_err = i2c_data_ready && (inj_mode == 2'd2);
  always @(posedge clk) begin
    if (reset) begin
      i2c_data_ready <= 1'b0;
      wcnt           <= 0;
      derr_used      <= 1'b0;
    end else if (i2c_data_valid && !i2c_data_ready) begin
      if (wcnt == ACK_DLY - 1) begin
        i2c_data_ready <= 1'b1;
        wcnt           <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      i2c_data_ready <= 1'b0;
      wcnt           <= 0;
      if (i2c_data_err) derr_used <= 1'b1;
    end
  end

  // Monitor: accepted bytes {nack, byte}, low-run length before each cmd_active rise, done pulses
  logic        clr;
  logic [8:0]  blog [32];
  int unsigned bn, gn, done_cnt, low_run;
  int unsigned gap [16];
  logic        act_d;
  always @(posedge clk) begin
    if (reset || clr) begin
      bn <= 0; gn <= 0; done_cnt <= 0; low_run <= 0; act_d <= 1'b0;
    end else begin
      if (i2c_data_valid && i2c_data_ready && bn < 32) begin
        blog[bn] <= {i2c_addr_err | i2c_data_err, i2c_data_in};
        bn       <= bn + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      act_d <= i2c_cmd_active;
      if (!i2c_cmd_active) low_run <= low_run + 1;
      else if (!act_d) begin
        if (gn < 16) gap[gn] <= low_run;
        gn      <= gn + 1;
        low_run <= 0;
      end
    end
  end

  int nchk, nerr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log;
    clr = 1'b1;
    tick;
    clr = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int c;
    c = 0;
    for (int i = 1; i <= BUDGET; i++) begin
      if (done || error) begin c = i; break; end
      tick;
    end
    chk({tag, " finish within budget"}, (c != 0), 1'b1);
    tick;
    tick;
  endtask

  task automatic wait_byte(input string tag, input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      if (i2c_data_valid && i2c_data_in == b) begin ok = 1'b1; break; end
      tick;
    end
    chk({tag, " byte seen"}, ok, 1'b1);
  endtask

  task automatic check_bytes(input string tag, input int n, input logic [47:0] b);
    chk({tag, " byte count"}, bn, n);
    for (int k = 0; k < n; k++)
      chk($sformatf("%s byte %0d", tag, k), blog[k], {1'b0, b[47-8*k -: 8]});
  endtask

  task automatic do_reset(input logic [1:0] mode);
    inj_mode = mode;
    reset    = 1'b1;
    tick; tick; tick;
    reset = 1'b0;
  endtask

  typedef struct packed {
    logic [7:0]  from;
    logic [7:0]  to;
    logic [3:0]  n;
    logic [47:0] bytes;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int fv, dl;
    nchk = 0; nerr = 0;
    start = 1'b0; start_from = '0; start_to = '0; clr = 1'b0; inj_mode = 2'd0;
    for (int i = 0; i < 256; i++) rom[i] = 16'hEEEE;
    rom[8'h00] = 16'h1080; rom[8'h01] = 16'h1101; rom[8'h02] = 16'h1202;
    rom[8'hFE] = 16'hA0B0; rom[8'hFF] = 16'hA1B1;
    rom[8'h10] = 16'h2030; rom[8'h11] = 16'h2131;

    vecs[0] = '{8'h00, 8'h03, 4'd6, 48'h1080_1101_1202};
    vecs[1] = '{8'h20, 8'h20, 4'd0, 48'h0};
    vecs[2] = '{8'hFE, 8'h01, 4'd6, 48'hA0B0_A1B1_1080};
    vecs[3] = '{8'h10, 8'h12, 4'd4, 48'h2030_2131_0000};
    vecs[4] = '{8'h01, 8'h02, 4'd2, 48'h1101_0000_0000};

    // Boot, clean bus
    reset = 1'b1;
    tick; tick; tick;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst error", error, 0);
    chk("rst pll_init", pll_initialized, 0);
    chk("rst err_count", err_count, 0);
    chk("rst cmd_active", i2c_cmd_active, 0);
    chk("rst data_valid", i2c_data_valid, 0);
    chk("rst data_in", i2c_data_in, 0);
    chk("rst rom_addr", rom_addr, 0);
    chk("cmd_addr", i2c_cmd_addr, 7'h60);
    chk("cmd_read", i2c_cmd_read, 0);
    chk("cmd_hs", i2c_cmd_high_speed, 0);
    reset = 1'b0;
    tick;
    chk("boot busy", busy, 1);
    wait_end("boot");
    check_bytes("boot", 6, 48'h1080_1101_1202);
    chk("boot transactions", gn, 3);
    chk("boot gap1", gap[1], 2);
    chk("boot gap2", gap[2], 2);
    chk("boot done pulses", done_cnt, 1);
    chk("boot pll_init", pll_initialized, 1);
    chk("boot busy end", busy, 0);
    chk("boot error", error, 0);

    // Single data NACK on first value byte
    do_reset(2'd1);
    wait_end("retry");
    chk("retry byte count", bn, 8);
    chk("retry nacked byte", blog[1], {1'b1, 8'h80});
    chk("retry resent reg", blog[2], {1'b0, 8'h10});
    chk("retry resent val", blog[3], {1'b0, 8'h80});
    chk("retry last byte", blog[7], {1'b0, 8'h02});
    chk("retry backoff gap", gap[1], DLY);
    chk("retry transactions", gn, 4);
    chk("retry err_count", err_count, 1);
    chk("retry error", error, 0);
    chk("retry done pulses", done_cnt, 1);
    chk("retry pll_init", pll_initialized, 1);

    // Address NACK on every attempt
    do_reset(2'd2);
    wait_end("abort");
    tick;
    chk("abort attempts", bn, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("abort attempt %0d", k), blog[k], {1'b1, 8'h10});
    chk("abort err_count", err_count, 4);
    chk("abort error", error, 1);
    chk("abort busy", busy, 0);
    chk("abort done pulses", done_cnt, 0);
    chk("abort pll_init", pll_initialized, 0);
    chk("abort backoff gap", gap[1], DLY);

    // Later start requests from a clean boot
    do_reset(2'd0);
    wait_end("reboot");
    chk("reboot err_count", err_count, 0);
    for (int v = 0; v < 5; v++) begin
      clear_log;
      start_from = vecs[v].from;
      start_to   = vecs[v].to;
      start      = 1'b1;
      tick;
      start = 1'b0;
      fv = 0; dl = 0;
      for (int c = 1; c <= BUDGET; c++) begin
        if (i2c_data_valid && fv == 0) fv = c;
        if (done) begin dl = c; break; end
        tick;
      end
      tick; tick;
      chk($sformatf("vec%0d finished", v), (dl != 0), 1'b1);
      if (vecs[v].n == 0) begin
        chk($sformatf("vec%0d done latency", v), dl, 2);
        chk($sformatf("vec%0d no valid", v), fv, 0);
      end else begin
        chk($sformatf("vec%0d first valid latency", v), fv, 3);
      end
      check_bytes($sformatf("vec%0d", v), vecs[v].n, vecs[v].bytes);
      chk($sformatf("vec%0d done pulses", v), done_cnt, 1);
      chk($sformatf("vec%0d error", v), error, 0);
      chk($sformatf("vec%0d busy", v), busy, 0);
    end

    // Start while busy is ignored
    clear_log;
    start_from = 8'h10; start_to = 8'h12; start = 1'b1;
    tick;
    start = 1'b0;
    wait_byte("ignore", 8'h20);
    start_from = 8'h01; start_to = 8'h02; start = 1'b1;
    tick;
    start = 1'b0;
    wait_end("ignore");
    check_bytes("ignore", 4, 48'h2030_2131_0000);
    chk("ignore done pulses", done_cnt, 1);

    // Reset in SEND_VAL of the second entry aborts the bus, then boot reruns
    start_from = 8'h00; start_to = 8'h03; start = 1'b1;
    tick;
    start = 1'b0;
    wait_byte("midreset", 8'h01);
    chk("midreset rom_addr before", rom_addr, 8'h01);
    reset = 1'b1;
    tick;
    chk("midreset cmd_active", i2c_cmd_active, 0);
    chk("midreset data_valid", i2c_data_valid, 0);
    chk("midreset busy", busy, 0);
    chk("midreset pll_init", pll_initialized, 0);
    reset = 1'b0;
    tick;
    chk("midreset rom_addr", rom_addr, 8'h00);
    chk("midreset busy after", busy, 1);
    wait_end("rerun");
    check_bytes("rerun", 6, 48'h1080_1101_1202);
    chk("rerun done pulses", done_cnt, 1);
    chk("rerun pll_init", pll_initialized, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
